// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate interface: the timing generator drives it, renderers consume it.
interface vga_timing_gen_if;
    localparam int unsigned COORD_W = 10;

    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               h_sync;
    logic               v_sync;
    logic               display_on;
    logic               frame_tick;
    logic               blink_signal;

    modport master (
        output pix_x, pix_y, h_sync, v_sync, display_on, frame_tick, blink_signal
    );

    modport slave (
        input  pix_x, pix_y, h_sync, v_sync, display_on, frame_tick, blink_signal
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, syncs, active-video flag,
// per-frame tick and a slow blink square wave. All outputs are registered
// and decoded from the next-state counter values so they stay aligned.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter bit          SYNC_ACTIVE  = 1'b0,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned CW       = 10;
    localparam int unsigned DW       = 11;
    localparam int unsigned BW       = 8;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Reject timings the 10-bit counters cannot hold and unusable blink periods.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (BLINK_FRAMES == 0 || BLINK_FRAMES > 255) begin : g_bad_blink
        $error("vga_timing_gen: BLINK_FRAMES must be in 1..255");
    end

    logic [1:0]    rst_sync_q, rst_sync_d;
    logic          rst_int_n;

    logic [CW-1:0] pix_x_q, pix_x_d;
    logic [CW-1:0] pix_y_q, pix_y_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          display_on_q, display_on_d;
    logic          frame_tick_q, frame_tick_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          h_win_c, v_win_c;

    // Reset release synchroniser: assertion is immediate, release waits two clocks.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    // Next-state counters and decode of the next-state position.
    always_comb begin
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        if (pix_ce) begin
            if (pix_x_q == CW'(H_TOTAL - 1)) begin
                pix_x_d = '0;
                if (pix_y_q == CW'(V_TOTAL - 1)) pix_y_d = '0;
                else                             pix_y_d = pix_y_q + CW'(1);
            end else begin
                pix_x_d = pix_x_q + CW'(1);
            end
        end

        h_win_c = (DW'(pix_x_d) >= DW'(HS_START)) && (DW'(pix_x_d) < DW'(HS_END));
        v_win_c = (DW'(pix_y_d) >= DW'(VS_START)) && (DW'(pix_y_d) < DW'(VS_END));

        h_sync_d     = h_win_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        v_sync_d     = v_win_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        display_on_d = (DW'(pix_x_d) < DW'(H_ACTIVE)) && (DW'(pix_y_d) < DW'(V_ACTIVE));

        // Only a real advance into (0, V_ACTIVE) fires the tick; holding drops it.
        frame_tick_d = pix_ce && (pix_x_d == '0) && (pix_y_d == CW'(V_ACTIVE));

        if (frame_tick_d) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            h_sync_q     <= ~SYNC_ACTIVE;
            v_sync_q     <= ~SYNC_ACTIVE;
            display_on_q <= 1'b1;
            frame_tick_q <= 1'b0;
            blink_q      <= 1'b1;
            blink_cnt_q  <= '0;
        end else begin
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            display_on_q <= display_on_d;
            frame_tick_q <= frame_tick_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign vga.pix_x        = pix_x_q;
    assign vga.pix_y        = pix_y_q;
    assign vga.h_sync       = h_sync_q;
    assign vga.v_sync       = v_sync_q;
    assign vga.display_on   = display_on_q;
    assign vga.frame_tick   = frame_tick_q;
    assign vga.blink_signal = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a tiny raster,
// and a 320-wide active-high variant) checked every cycle against a
// linear-position reference model, plus a vector table and corner sequences.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;
    logic [2:0] ce;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if2 ();

    vga_timing_gen u_def (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (ce[0]),
        .vga    (if0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE(1'b0), .BLINK_FRAMES(3)
    ) u_small (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (ce[1]),
        .vga    (if1)
    );

    vga_timing_gen #(
        .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE(1'b1), .BLINK_FRAMES(2)
    ) u_half (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (ce[2]),
        .vga    (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, bf;
        bit sa;
    } cfg_t;

    typedef struct {
        logic rst;
        logic ce;
        int   x;
        int   y;
        logic hs, vs, de, ft, bl;
    } vec_t;

    cfg_t cfg [3];
    vec_t vecs[$];

    // Reference model: linear raster position, tick count since reset.
    int mpos   [3];
    int mticks [3];
    bit mtick  [3];
    int hold;

    int n_total;
    int n_pass;

    function automatic int htot(int i);
        return cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
    endfunction

    function automatic int vtot(int i);
        return cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
    endfunction

    function automatic logic [24:0] exp_out(int i);
        int   x, y;
        logic hs, vs, de, bl;
        x  = mpos[i] % htot(i);
        y  = mpos[i] / htot(i);
        hs = (x >= cfg[i].ha + cfg[i].hf && x < cfg[i].ha + cfg[i].hf + cfg[i].hs)
             ? cfg[i].sa : ~cfg[i].sa;
        vs = (y >= cfg[i].va + cfg[i].vf && y < cfg[i].va + cfg[i].vf + cfg[i].vs)
             ? cfg[i].sa : ~cfg[i].sa;
        de = (x < cfg[i].ha) && (y < cfg[i].va);
        bl = ((mticks[i] / cfg[i].bf) % 2) == 0;
        return {10'(x), 10'(y), hs, vs, de, mtick[i], bl};
    endfunction

    function automatic logic [24:0] act_out(int i);
        case (i)
            0:       return {if0.pix_x, if0.pix_y, if0.h_sync, if0.v_sync,
                             if0.display_on, if0.frame_tick, if0.blink_signal};
            1:       return {if1.pix_x, if1.pix_y, if1.h_sync, if1.v_sync,
                             if1.display_on, if1.frame_tick, if1.blink_signal};
            default: return {if2.pix_x, if2.pix_y, if2.h_sync, if2.v_sync,
                             if2.display_on, if2.frame_tick, if2.blink_signal};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mpos[i]   = 0;
            mticks[i] = 0;
            mtick[i]  = 1'b0;
        end
        hold = 2;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare #1 later.
    task automatic step(input logic [2:0] ce_v, input logic rst_v);
        @(negedge clk);
        rst_n = rst_v;
        ce    = ce_v;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            mtick[i] = 1'b0;
            if (!rst_v) begin
                mpos[i]   = 0;
                mticks[i] = 0;
            end else if (hold == 0 && ce_v[i]) begin
                mpos[i] = (mpos[i] + 1) % (htot(i) * vtot(i));
                if (mpos[i] == cfg[i].va * htot(i)) begin
                    mtick[i] = 1'b1;
                    mticks[i]++;
                end
            end
        end
        if (!rst_v)       hold = 2;
        else if (hold > 0) hold--;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("model_inst%0d", i), 32'(act_out(i)), 32'(exp_out(i)));
    endtask

    task automatic align(input int i, input int target, input logic [2:0] ce_v);
        for (int n = 0; n < 5000 && mpos[i] != target; n++) step(ce_v, 1'b1);
        if (mpos[i] != target) begin
            n_total++;
            $display("FAIL align_inst%0d: actual=%0d required=%0d", i, mpos[i], target);
        end
    endtask

    function automatic void add_vec(logic r, logic c, int x, int y,
                                    logic hs, logic vs, logic de, logic ft, logic bl);
        vec_t v;
        v.rst = r; v.ce = c; v.x = x; v.y = y;
        v.hs = hs; v.vs = vs; v.de = de; v.ft = ft; v.bl = bl;
        vecs.push_back(v);
    endfunction

    initial begin
        int hs_cnt, de_cnt, vs_cnt, tick_cnt, tx, ty;
        int toggles, stray, t_before;
        logic prev_bl;

        n_total = 0;
        n_pass  = 0;
        cfg[0] = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, bf:30, sa:1'b0};
        cfg[1] = '{ha:8,   hf:2,  hs:3,  hb:3,  va:6,   vf:1,  vs:2, vb:2,  bf:3,  sa:1'b0};
        cfg[2] = '{ha:320, hf:8,  hs:48, hb:24, va:4,   vf:1,  vs:1, vb:1,  bf:2,  sa:1'b1};

        // Small-raster vectors: reset, two-clock release, ce hold, h_sync window, line wrap.
        add_vec(0, 1,  0, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  0, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  0, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  1, 0, 1, 1, 1, 0, 1);
        add_vec(1, 0,  1, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  2, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  3, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  4, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  5, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  6, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  7, 0, 1, 1, 1, 0, 1);
        add_vec(1, 1,  8, 0, 1, 1, 0, 0, 1);
        add_vec(1, 1,  9, 0, 1, 1, 0, 0, 1);
        add_vec(1, 1, 10, 0, 0, 1, 0, 0, 1);
        add_vec(1, 0, 10, 0, 0, 1, 0, 0, 1);
        add_vec(1, 1, 11, 0, 0, 1, 0, 0, 1);
        add_vec(1, 1, 12, 0, 0, 1, 0, 0, 1);
        add_vec(1, 1, 13, 0, 1, 1, 0, 0, 1);
        add_vec(1, 1, 14, 0, 1, 1, 0, 0, 1);
        add_vec(1, 1, 15, 0, 1, 1, 0, 0, 1);
        add_vec(1, 1,  0, 1, 1, 1, 1, 0, 1);

        rst_n = 1'b1;
        ce    = 3'b000;
        model_reset();
        #3 rst_n = 1'b0;

        foreach (vecs[k]) begin
            step({3{vecs[k].ce}}, vecs[k].rst);
            check($sformatf("vec%0d", k), 32'(act_out(1)),
                  32'({10'(vecs[k].x), 10'(vecs[k].y), vecs[k].hs, vecs[k].vs,
                       vecs[k].de, vecs[k].ft, vecs[k].bl}));
        end

        // Default timing: one full 800-pixel line.
        align(0, 800, 3'b111);
        hs_cnt = 0;
        de_cnt = 0;
        for (int n = 0; n < 800; n++) begin
            step(3'b111, 1'b1);
            if (if0.h_sync == 1'b0) hs_cnt++;
            if (if0.display_on)     de_cnt++;
            if (n == 654) check("def_hs_before_656", 32'(if0.h_sync), 32'(1));
            if (n == 655) check("def_hs_at_656", 32'(if0.h_sync), 32'(0));
            if (n == 751) check("def_hs_at_752", 32'(if0.h_sync), 32'(1));
        end
        check("def_hsync_low_cycles", 32'(hs_cnt), 32'(96));
        check("def_display_cycles", 32'(de_cnt), 32'(640));
        check("def_line_wrap", 32'({if0.pix_x, if0.pix_y}), 32'({10'd0, 10'd2}));

        // Alternating pix_ce: a 16-pixel line takes 32 clocks.
        align(1, 32, 3'b010);
        for (int n = 0; n < 32; n++) begin
            step((n % 2 == 0) ? 3'b010 : 3'b000, 1'b1);
            if (n == 15) check("ce_half_line_x", 32'(if1.pix_x), 32'(8));
        end
        check("ce_line_end", 32'({if1.pix_x, if1.pix_y}), 32'({10'd0, 10'd3}));

        // One full small frame: vertical sync width and single tick position.
        align(1, 0, 3'b010);
        vs_cnt   = 0;
        tick_cnt = 0;
        tx       = -1;
        ty       = -1;
        for (int n = 0; n < 176; n++) begin
            step(3'b010, 1'b1);
            if (if1.v_sync == 1'b0) vs_cnt++;
            if (if1.frame_tick) begin
                tick_cnt++;
                tx = int'(if1.pix_x);
                ty = int'(if1.pix_y);
            end
        end
        check("frame_vsync_cycles", 32'(vs_cnt), 32'(32));
        check("frame_tick_count", 32'(tick_cnt), 32'(1));
        check("frame_tick_pos", 32'({16'(tx), 16'(ty)}), 32'({16'd0, 16'd6}));
        check("frame_wrap", 32'({if1.pix_x, if1.pix_y}), 32'(0));

        // Hold pix_ce low at the tick: tick lasts one clock only.
        align(1, 95, 3'b010);
        step(3'b010, 1'b1);
        check("tick_hold_first", 32'(if1.frame_tick), 32'(1));
        for (int n = 0; n < 10; n++) begin
            step(3'b000, 1'b1);
            check($sformatf("tick_hold_%0d", n), 32'(if1.frame_tick), 32'(0));
        end

        // Blink over eight small frames: toggles only on ticks, every third tick.
        t_before = mticks[1];
        prev_bl  = if1.blink_signal;
        toggles  = 0;
        stray    = 0;
        for (int n = 0; n < 8 * 176; n++) begin
            step(3'b111, 1'b1);
            if (if1.blink_signal != prev_bl) begin
                toggles++;
                if (!if1.frame_tick) stray++;
            end
            prev_bl = if1.blink_signal;
        end
        check("blink_stray_toggles", 32'(stray), 32'(0));
        check("blink_toggle_count", 32'(toggles), 32'(mticks[1] / 3 - t_before / 3));

        // Randomised pix_ce on all instances.
        for (int n = 0; n < 3000; n++) step(3'($urandom), 1'b1);

        // Asynchronous reset mid-frame: immediate reset levels, restart at (0,0).
        align(1, 3 * 16 + 10, 3'b010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("async_rst_inst%0d", i), 32'(act_out(i)), 32'(exp_out(i)));
        for (int n = 0; n < 3; n++) step(3'b111, 1'b0);
        for (int n = 0; n < 5; n++) step(3'b111, 1'b1);
        check("rst_resume_x", 32'(if1.pix_x), 32'(3));

        // Half-width, active-high variant: one 400-pixel line.
        align(2, 400, 3'b100);
        hs_cnt = 0;
        de_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            step(3'b100, 1'b1);
            if (if2.h_sync == 1'b1) hs_cnt++;
            if (if2.display_on)     de_cnt++;
            if (n == 327) check("half_hs_at_328", 32'(if2.h_sync), 32'(1));
            if (n == 375) check("half_hs_at_376", 32'(if2.h_sync), 32'(0));
        end
        check("half_hsync_high_cycles", 32'(hs_cnt), 32'(48));
        check("half_display_cycles", 32'(de_cnt), 32'(320));
        check("half_line_wrap", 32'({if2.pix_x, if2.pix_y}), 32'({10'd0, 10'd2}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
